// File: rtl/prog_loader_pkg.sv
// prog_loader shared definitions: command codes,
// FSM state type and byte-count helper.
package prog_loader_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_SETADDR = 8'h02;
  localparam logic [7:0] CMD_RUN     = 8'h03;
  localparam logic [7:0] CMD_CLEAR   = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_ADDR,
    S_CHECK,
    S_WRITE,
    S_RUN
  } state_e;

  function automatic int ceil_div8(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/prog_byte_shifter.sv
// MSB-first byte accumulator with byte counter,
// shared by the data and address paths of prog_loader.
module prog_byte_shifter #(
  parameter int OW = 12,
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          shift,
  input  logic [7:0]    din,
  output logic [OW-1:0] value_nxt,
  output logic [CW-1:0] count
);

  logic [OW-1:0] value_q, value_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    value_nxt = (value_q << 8) | OW'(din);
    value_d   = value_q;
    cnt_d     = cnt_q;
    if (clr) begin
      value_d = '0;
      cnt_d   = '0;
    end else if (shift) begin
      value_d = value_nxt;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// UART byte-stream program loader with memory write handshake.
// Define PROG_LOADER_CHECKSUM_EN for a trailing checksum byte per WRITE.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORD_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 8,
  parameter int RESET_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WORD_WIDTH-1:0] mem_data,
  output logic                  mem_write,
  input  logic                  mem_ready,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  err_command,
  output logic                  err_overrun,
  output logic                  err_checksum
);

  localparam int BPW = ceil_div8(WORD_WIDTH);
  localparam int AB  = ceil_div8(ADDR_WIDTH);
  localparam int NB  = (BPW > AB) ? BPW : AB;
  localparam int CW  = $clog2(NB + 1);
  localparam int OW  =
    (WORD_WIDTH > ADDR_WIDTH) ? WORD_WIDTH : ADDR_WIDTH;
  localparam int RW  = $clog2(RESET_CYCLES + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [RW-1:0]         run_q, run_d;
  logic                  ecmd_q, ecmd_d;
  logic                  eovr_q, eovr_d;
  logic                  echk_d;
  logic [OW-1:0]         sh_nxt;
  logic [CW-1:0]         sh_cnt;
  logic                  sh_clr, sh_shift;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       echk_q;
`endif

  assign sh_clr   = (state_q == S_IDLE);
  assign sh_shift = rx_valid &&
    ((state_q == S_DATA) || (state_q == S_ADDR));

  prog_byte_shifter #(
    .OW (OW),
    .CW (CW)
  ) u_shifter (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (sh_clr),
    .shift     (sh_shift),
    .din       (rx_data),
    .value_nxt (sh_nxt),
    .count     (sh_cnt)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    run_d   = run_q;
    ecmd_d  = ecmd_q;
    eovr_d  = eovr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    echk_d  = echk_q;
    sum_d   = sum_q;
`else
    echk_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            CMD_WRITE: begin
              state_d = S_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
              sum_d   = rx_data;
`endif
            end
            CMD_SETADDR: state_d = S_ADDR;
            CMD_RUN: begin
              state_d = S_RUN;
              addr_d  = '0;
              run_d   = '0;
            end
            CMD_CLEAR: begin
              ecmd_d = 1'b0;
              eovr_d = 1'b0;
              echk_d = 1'b0;
            end
            default: ecmd_d = 1'b1;
          endcase
        end
      end
      S_DATA: begin
        if (rx_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          if (sh_cnt == CW'(BPW - 1)) begin
            data_d = sh_nxt[WORD_WIDTH-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_WRITE;
`endif
          end
        end
      end
      S_ADDR: begin
        if (rx_valid && (sh_cnt == CW'(AB - 1))) begin
          addr_d  = sh_nxt[ADDR_WIDTH-1:0];
          state_d = S_IDLE;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_IDLE;
            echk_d  = 1'b1;
          end
        end
      end
`endif
      S_WRITE: begin
        if (rx_valid) eovr_d = 1'b1;
        if (mem_ready) begin
          addr_d  = addr_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (rx_valid) eovr_d = 1'b1;
        if (run_q == RW'(RESET_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      run_q   <= '0;
      ecmd_q  <= 1'b0;
      eovr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      run_q   <= run_d;
      ecmd_q  <= ecmd_d;
      eovr_q  <= eovr_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sum_q  <= '0;
      echk_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      echk_q <= echk_d;
    end
  end
  assign err_checksum = echk_q;
`else
  assign err_checksum = echk_d;
`endif

  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_write   = (state_q == S_WRITE);
  assign cpu_reset   = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign err_command = ecmd_q;
  assign err_overrun = eovr_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed scoreboard bench for prog_loader (default parameters).
// Checksum-mode steps are included when PROG_LOADER_CHECKSUM_EN is set.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  mem_address;
  logic [11:0] mem_data;
  logic        mem_write;
  logic        mem_ready;
  logic        cpu_reset;
  logic        busy;
  logic        err_command;
  logic        err_overrun;
  logic        err_checksum;

  int compared = 0;
  int mismatched = 0;

  logic [19:0] sb[$];
  logic [7:0]  model_addr;

  prog_loader #(
    .WORD_WIDTH   (12),
    .ADDR_WIDTH   (8),
    .RESET_CYCLES (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_write    (mem_write),
    .mem_ready    (mem_ready),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .err_command  (err_command),
    .err_overrun  (err_overrun),
    .err_checksum (err_checksum)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepted writes are popped from the scoreboard here.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && mem_write === 1'b1 &&
        mem_ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL unexpected_write: got %0h/%0h expected none",
               mem_address, mem_data);
      end else begin
        logic [19:0] e;
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_address), 32'(e[19:12]));
        chk("wr_data", 32'(mem_data), 32'(e[11:0]));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_pkt(input logic [7:0] b1,
                          input logic [7:0] b0);
    send(8'h01);
    send(b1);
    send(b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h01 + b1 + b0);
`endif
  endtask

  task automatic push_exp(input logic [7:0] b1,
                          input logic [7:0] b0);
    logic [15:0] w;
    w = {b1, b0};
    sb.push_back({model_addr, w[11:0]});
    model_addr = model_addr + 8'd1;
  endtask

  task automatic wr(input logic [7:0] b1,
                    input logic [7:0] b0);
    push_exp(b1, b0);
    send_pkt(b1, b0);
    idle(1);
  endtask

  initial begin
    logic [7:0]  sa;
    logic [11:0] sd;
    int          pulse;
    reset_n    = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    mem_ready  = 1'b1;
    model_addr = 8'h00;
    idle(2);
    reset_n = 1'b1;

    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_write", 32'(mem_write), 0);
    chk("rst_cpu", 32'(cpu_reset), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs",
        32'({err_command, err_overrun, err_checksum}), 0);

    // First write, then the address moves on by one.
    wr(8'hAB, 8'hCD);
    chk("w1_done", 32'(mem_write), 0);
    wr(8'h11, 8'h22);

    // Address set to the top, then wrap to zero.
    send(8'h02);
    send(8'hFF);
    model_addr = 8'hFF;
    chk("setaddr", 32'(mem_address), 32'h FF);
    wr(8'h00, 8'h12);
    wr(8'h00, 8'h34);
    chk("wrap_addr", 32'(mem_address), 32'h01);

    // Stalled write with a byte arriving meanwhile.
    mem_ready = 1'b0;
    push_exp(8'h12, 8'h34);
    send_pkt(8'h12, 8'h34);
    @(negedge clock);
    chk("stall_wr", 32'(mem_write), 1);
    sa = mem_address;
    sd = mem_data;
    chk("stall_addr0", 32'(sa), 32'h01);
    chk("stall_data0", 32'(sd), 32'h234);
    send(8'h55);
    repeat (3) begin
      @(negedge clock);
      chk("stall_hold", 32'(mem_write), 1);
      chk("stall_addr", 32'(mem_address), 32'(sa));
      chk("stall_data", 32'(mem_data), 32'(sd));
    end
    @(posedge clock);
    #1;
    mem_ready = 1'b1;
    idle(1);
    chk("stall_end", 32'(mem_write), 0);
    chk("overrun", 32'(err_overrun), 1);
    chk("drop_idle", 32'(busy), 0);
    chk("stall_next", 32'(mem_address), 32'h02);

    // Run pulse.
    send(8'h03);
    model_addr = 8'h00;
    pulse = 0;
    repeat (8) begin
      if (cpu_reset === 1'b1) pulse++;
      idle(1);
    end
    chk("run_pulse", 32'(pulse), 4);
    chk("run_addr", 32'(mem_address), 0);
    chk("run_busy", 32'(busy), 0);

    send(8'h7E);
    chk("err_cmd", 32'(err_command), 1);
    chk("cmd_idle", 32'(busy), 0);
    send(8'h04);
    chk("clear",
        32'({err_command, err_overrun, err_checksum}), 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    wr(8'h0A, 8'hBC);
    send(8'h01);
    send(8'h0A);
    send(8'hBC);
    send(8'h00);
    chk("cks_err", 32'(err_checksum), 1);
    chk("cks_idle", 32'(busy), 0);
    chk("cks_addr", 32'(mem_address), 32'(model_addr));
    send(8'h04);
`endif

    // Reset mid-packet drops the partial word.
    send(8'h01);
    send(8'hAB);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    model_addr = 8'h00;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wr", 32'(mem_write), 0);
    wr(8'h00, 8'h01);

    idle(3);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
